microsequencer: RTL and testbench
=================================

// Module: microsequencer
// PURPOSE
//  Control-unit next-state engine. Consumes the 7-bit microstate code from the
//  instruction encoder and holds the current microstate register driving the
//  control ROM. Next state is chosen by ROM field ns: encoder, increment, jump,
//  conditional jump, wait-on-MOC, or call/return via a small return stack.
// PARAMETERS
//  STATE_W      7    microstate width (matches encoder output)
//  FETCH_STATE  1    state entered on empty RETURN, failed cond and watchdog
//  STK_DEPTH    4    return-stack entries (power of 2, >=2)
//  WDT_LIMIT    255  max consecutive MOC-wait cycles (only with MSEQ_WATCHDOG_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        async active-low reset
//  enc_state  in   STATE_W  encoder output (decoded instruction entry state)
//  cond_pass  in   1        instruction condition field satisfied (from cond tester)
//  ns         in   3        next-state select from control ROM
//  cr_addr    in   STATE_W  jump/call target from control ROM
//  inv        in   1        invert sense of cond_true for COND_JUMP
//  cond_true  in   1        tested status condition for COND_JUMP
//  moc        in   1        memory operation complete
//  hold       in   1        freeze sequencer this cycle
//  state      out  STATE_W  current microstate (control ROM address)
//  stk_ovf    out  1        sticky: CALL with full stack
//  stk_unf    out  1        sticky: RETURN with empty stack
//  wdt_to     out  1        sticky watchdog timeout (0 when macro absent)
// BEHAVIOUR
//  - reset_n low (async): state=0, stack empty, stk_ovf/stk_unf/wdt_to=0, wdt cnt=0.
//  - One update per clk; state registered, no combinational path input->state.
//  - Priority: reset > hold (all regs frozen, incl. wdt cnt) > ns decode.
//  - ns encodings:
//    000 DECODE : cond_pass ? enc_state : FETCH_STATE.
//    001 INCR   : state+1, mod 2^STATE_W (127 -> 0).
//    010 JUMP   : cr_addr.
//    011 CJUMP  : (cond_true^inv) ? cr_addr : state+1.
//    100 WAIT   : moc ? state+1 : state.
//    101 WAITJ  : moc ? cr_addr : state.
//    110 CALL   : push state+1, go cr_addr. Full: push dropped, stk_ovf<=1, still jump.
//    111 RETURN : pop -> state. Empty: state<=FETCH_STATE, stk_unf<=1.
//  - Stack is LIFO, depth tracked 0..STK_DEPTH; one push or pop per cycle max.
//  - Sticky flags clear only on reset.
//  - Reset mid-WAIT: abandons wait; next state after release follows ns from 0.
// CONFIGURATION
//  - MSEQ_WATCHDOG_EN defined: counter increments each non-held cycle in WAIT/WAITJ
//    with moc=0; clears on any other cycle. When it reaches WDT_LIMIT with moc
//    still 0, the next edge forces state=FETCH_STATE, empties stack, sets wdt_to,
//    clears counter. moc=1 on that cycle wins (normal transition).
//  - Not defined: no counter logic; wdt_to tied 0; WAIT may hold indefinitely.
// STRUCTURE
//  - Package mseq_pkg: STATE_W, ns encodings (NS_DECODE..NS_RETURN) as localparams.
//  - Sub-module mseq_stack: LIFO (push, pop, din, dout, full, empty), async reset.
//  - Top: next-state mux, state register, sticky flags, optional watchdog.
// TESTING
//  - Reset: assert reset_n=0 mid-cycle -> state=0, all flags 0 immediately.
//  - DECODE: enc_state=7'b0101100, cond_pass=1 -> state=44; cond_pass=0 -> state=1.
//  - CJUMP: state=10, cr_addr=40, cond_true=1, inv=1 -> state=11; inv=0 -> 40.
//  - WAIT: state=20, moc=0 x3 cycles -> holds 20; moc=1 -> 21; hold=1 freezes.
//  - Stack: 4 CALLs from 5,9,13,17 -> 5th CALL sets stk_ovf; 4 RETURNs yield 18,14,
//    10,6; 5th RETURN -> state=1, stk_unf=1. INCR at 127 -> 0.
//  - Watchdog (macro on, WDT_LIMIT=3): WAIT with moc=0 -> after limit, state=1,
//    wdt_to=1; macro off: same stimulus holds state, wdt_to=0.

Source files
------------

// File: rtl/mseq_pkg.sv
// Microsequencer shared definitions: state width and next-state
// select encodings from the control ROM ns field.
package mseq_pkg;

  localparam int STATE_W = 7;

  localparam logic [2:0] NS_DECODE = 3'd0;
  localparam logic [2:0] NS_INCR   = 3'd1;
  localparam logic [2:0] NS_JUMP   = 3'd2;
  localparam logic [2:0] NS_CJUMP  = 3'd3;
  localparam logic [2:0] NS_WAIT   = 3'd4;
  localparam logic [2:0] NS_WAITJ  = 3'd5;
  localparam logic [2:0] NS_CALL   = 3'd6;
  localparam logic [2:0] NS_RETURN = 3'd7;

endpackage

// File: rtl/mseq_stack.sv
// Microsequencer return stack: small LIFO with occupancy count,
// one push or pop per cycle, flush empties it in one edge.
module mseq_stack #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    cntM1;

  assign cntM1 = count - CW'(1);
  assign dout  = mem[cntM1[AW-1:0]];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !full) begin
      mem[count[AW-1:0]] <= din;
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= cntM1;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: next-state mux, state register, sticky stack flags.
// Optional MOC-wait watchdog enabled by defining MSEQ_WATCHDOG_EN.
module microsequencer
  import mseq_pkg::*;
#(
  parameter logic [STATE_W-1:0] FETCH_STATE = STATE_W'(1),
  parameter int STK_DEPTH = 4,
  parameter int WDT_LIMIT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               cond_pass,
  input  logic [2:0]         ns,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic               inv,
  input  logic               cond_true,
  input  logic               moc,
  input  logic               hold,
  output logic [STATE_W-1:0] state,
  output logic               stk_ovf,
  output logic               stk_unf,
  output logic               wdt_to
);

  logic [STATE_W-1:0] stateInc;
  logic [STATE_W-1:0] stateNext;
  logic [STATE_W-1:0] stkDout;
  logic stkFull, stkEmpty;
  logic push, pop;
  logic ovfSet, unfSet;
  logic wdtFire;

  assign stateInc = state + STATE_W'(1);

  always_comb begin
    stateNext = state;
    push      = 1'b0;
    pop       = 1'b0;
    ovfSet    = 1'b0;
    unfSet    = 1'b0;
    unique case (ns)
      NS_DECODE: stateNext = cond_pass ? enc_state : FETCH_STATE;
      NS_INCR:   stateNext = stateInc;
      NS_JUMP:   stateNext = cr_addr;
      NS_CJUMP:  stateNext = (cond_true ^ inv) ? cr_addr : stateInc;
      NS_WAIT:   stateNext = moc ? stateInc : state;
      NS_WAITJ:  stateNext = moc ? cr_addr : state;
      NS_CALL: begin
        stateNext = cr_addr;
        push      = !stkFull;
        ovfSet    = stkFull;
      end
      NS_RETURN: begin
        if (stkEmpty) begin
          stateNext = FETCH_STATE;
          unfSet    = 1'b1;
        end else begin
          stateNext = stkDout;
          pop       = 1'b1;
        end
      end
      default: stateNext = state;
    endcase
  end

  mseq_stack #(
    .WIDTH(STATE_W),
    .DEPTH(STK_DEPTH)
  ) uStack (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push && !hold && !wdtFire),
    .pop    (pop && !hold && !wdtFire),
    .flush  (wdtFire),
    .din    (stateInc),
    .dout   (stkDout),
    .full   (stkFull),
    .empty  (stkEmpty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (!hold) begin
      state   <= wdtFire ? FETCH_STATE : stateNext;
      stk_ovf <= stk_ovf | ovfSet;
      stk_unf <= stk_unf | unfSet;
    end
  end

`ifdef MSEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_LIMIT + 1);

  logic [WDT_W-1:0] wdtCnt;
  logic waitIdle;

  // held cycles neither count nor fire
  assign waitIdle = !hold && !moc &&
                    (ns == NS_WAIT || ns == NS_WAITJ);
  assign wdtFire = waitIdle && (wdtCnt == WDT_W'(WDT_LIMIT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdtCnt <= '0;
      wdt_to <= 1'b0;
    end else if (!hold) begin
      if (wdtFire) begin
        wdtCnt <= '0;
        wdt_to <= 1'b1;
      end else if (waitIdle) begin
        wdtCnt <= wdtCnt + WDT_W'(1);
      end else begin
        wdtCnt <= '0;
      end
    end
  end
`else
  logic unusedWdt;

  assign unusedWdt = (WDT_LIMIT > 0);
  assign wdtFire   = 1'b0;
  assign wdt_to    = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer.
// Watchdog expectations follow MSEQ_WATCHDOG_EN.
module tb_microsequencer;
  import mseq_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic [6:0] enc_state, cr_addr, state;
  logic cond_pass, inv, cond_true, moc, hold;
  logic [2:0] ns;
  logic stk_ovf, stk_unf, wdt_to;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  microsequencer #(
    .STK_DEPTH(4),
    .WDT_LIMIT(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enc_state(enc_state),
    .cond_pass(cond_pass),
    .ns       (ns),
    .cr_addr  (cr_addr),
    .inv      (inv),
    .cond_true(cond_true),
    .moc      (moc),
    .hold     (hold),
    .state    (state),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf),
    .wdt_to   (wdt_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jumpTo(input logic [6:0] a);
    ns = NS_JUMP;
    cr_addr = a;
    step();
  endtask

  logic [6:0] callFrom [4];
  logic [6:0] retExp [4];

  initial begin
    callFrom[0] = 7'd5;  callFrom[1] = 7'd9;
    callFrom[2] = 7'd13; callFrom[3] = 7'd17;
    retExp[0] = 7'd18; retExp[1] = 7'd14;
    retExp[2] = 7'd10; retExp[3] = 7'd6;

    reset_n = 1'b0;
    enc_state = '0; cr_addr = 7'd99; cond_pass = 1'b0;
    inv = 1'b0; cond_true = 1'b0; moc = 1'b0; hold = 1'b0;
    ns = NS_JUMP;
    step();
    step();
    chk("rst_state", 32'(state), 0);
    chk("rst_ovf", 32'(stk_ovf), 0);
    chk("rst_unf", 32'(stk_unf), 0);
    chk("rst_wdt", 32'(wdt_to), 0);
    reset_n = 1'b1;

    ns = NS_DECODE; enc_state = 7'b0101100; cond_pass = 1'b1;
    step();
    chk("decode_pass", 32'(state), 44);
    cond_pass = 1'b0;
    step();
    chk("decode_fail", 32'(state), 1);

    jumpTo(7'd10);
    chk("jump", 32'(state), 10);
    ns = NS_CJUMP; cr_addr = 7'd40; cond_true = 1'b1; inv = 1'b1;
    step();
    chk("cjump_inv", 32'(state), 11);
    jumpTo(7'd10);
    ns = NS_CJUMP; cr_addr = 7'd40; inv = 1'b0;
    step();
    chk("cjump_take", 32'(state), 40);

    jumpTo(7'd20);
    ns = NS_WAIT; moc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_hold", 32'(state), 20);
    end
    moc = 1'b1; hold = 1'b1;
    step();
    chk("hold_freeze", 32'(state), 20);
    hold = 1'b0;
    step();
    chk("wait_moc", 32'(state), 21);
    ns = NS_WAITJ; cr_addr = 7'd50;
    step();
    chk("waitj_moc", 32'(state), 50);
    moc = 1'b0;

    for (int i = 0; i < 4; i++) begin
      jumpTo(callFrom[i]);
      ns = NS_CALL; cr_addr = 7'd100;
      step();
      chk("call_tgt", 32'(state), 100);
    end
    chk("call4_ovf", 32'(stk_ovf), 0);
    jumpTo(7'd21);
    ns = NS_CALL; cr_addr = 7'd60;
    step();
    chk("call5_tgt", 32'(state), 60);
    chk("call5_ovf", 32'(stk_ovf), 1);

    ns = NS_RETURN; hold = 1'b1;
    step();
    chk("ret_held", 32'(state), 60);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ret_pop", 32'(state), 32'(retExp[i]));
    end
    chk("ret4_unf", 32'(stk_unf), 0);
    step();
    chk("ret5_state", 32'(state), 1);
    chk("ret5_unf", 32'(stk_unf), 1);

    jumpTo(7'd127);
    ns = NS_INCR;
    step();
    chk("incr_wrap", 32'(state), 0);
    step();
    chk("incr_1", 32'(state), 1);

    jumpTo(7'd30);
    ns = NS_WAIT; moc = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("wdt_pre", 32'(state), 30);
    chk("wdt_pre_to", 32'(wdt_to), 0);
    step();
`ifdef MSEQ_WATCHDOG_EN
    chk("wdt_state", 32'(state), 1);
    chk("wdt_to", 32'(wdt_to), 1);
`else
    chk("wdt_state", 32'(state), 30);
    chk("wdt_to", 32'(wdt_to), 0);
`endif

    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_ovf", 32'(stk_ovf), 0);
    chk("arst_unf", 32'(stk_unf), 0);
    chk("arst_wdt", 32'(wdt_to), 0);
    ns = NS_INCR;
    #2 reset_n = 1'b1;
    step();
    chk("post_rst_incr", 32'(state), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
